// File: rtl/rc4_drop_stream.sv
// RC4 stream cipher: byte-serial key load, 256-cycle KSA, optional keystream drop,
// then one PRGA step per accepted plaintext byte with a one-cycle output register.
module rc4_drop_stream #(
    parameter int unsigned MAX_KEY_BYTES = 32,
    parameter int unsigned DROP_N        = 0
) (
    input  logic       CLK_IN,
    input  logic       RESET_IN,
    input  logic       START_IN,
    input  logic       STOP_IN,
    input  logic [7:0] KEY_SIZE_IN,
    input  logic [7:0] KEY_BYTE_IN,
    input  logic       KEY_VALID_IN,
    output logic       KEY_READY_OUT,
    input  logic [7:0] DATA_IN,
    input  logic       DATA_VALID_IN,
    output logic       DATA_READY_OUT,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID_OUT,
    input  logic       DATA_READY_IN,
    output logic       BUSY_OUT,
    output logic       ERROR_OUT
);
    localparam int unsigned KIDX_W = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, KEY_LOAD, KSA, DROP, STREAM} state_t;

    state_t      state_q, state_d;
    logic [7:0]  sbox [256];
    logic [7:0]  key_mem [MAX_KEY_BYTES];
    logic [7:0]  i_q, j_q, k_q, key_len_q, load_idx_q;
    logic [15:0] drop_cnt_q;

    logic       key_legal_c, key_acc_c, data_acc_c, drop_last_c;
    logic [7:0] ksa_si_c, ksa_j_c;
    logic [7:0] p_i_c, p_si_c, p_j_c, p_sj_c, p_t_c, p_k_c;

    // Handshake qualifiers and key-size legality
    assign key_legal_c    = (KEY_SIZE_IN != 8'd0) && ({1'b0, KEY_SIZE_IN} <= 9'(MAX_KEY_BYTES));
    assign key_acc_c      = (state_q == KEY_LOAD) && KEY_VALID_IN && KEY_READY_OUT;
    assign DATA_READY_OUT = (state_q == STREAM) && (!DATA_VALID_OUT || DATA_READY_IN);
    assign data_acc_c     = DATA_VALID_IN && DATA_READY_OUT;
    assign drop_last_c    = (drop_cnt_q == 16'(DROP_N - 1));

    // KSA step: j + S[i] + key[k]
    assign ksa_si_c = sbox[i_q];
    assign ksa_j_c  = j_q + ksa_si_c + key_mem[KIDX_W'(k_q)];

    // PRGA step; keystream byte is taken from the post-swap S-box
    assign p_i_c  = i_q + 8'd1;
    assign p_si_c = sbox[p_i_c];
    assign p_j_c  = j_q + p_si_c;
    assign p_sj_c = sbox[p_j_c];
    assign p_t_c  = p_si_c + p_sj_c;
    assign p_k_c  = (p_t_c == p_i_c) ? p_sj_c :
                    (p_t_c == p_j_c) ? p_si_c : sbox[p_t_c];

    // Next-state logic; STOP_IN overrides everything but reset
    always_comb begin
        state_d = state_q;
        if (STOP_IN) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (START_IN && key_legal_c) state_d = KEY_LOAD;
                KEY_LOAD: if (key_acc_c && (load_idx_q == key_len_q - 8'd1)) state_d = KSA;
                KSA:      if (i_q == 8'hFF) state_d = (DROP_N > 0) ? DROP : STREAM;
                DROP:     if (drop_last_c) state_d = STREAM;
                STREAM:   state_d = STREAM;
                default:  state_d = IDLE;
            endcase
        end
    end

    // State register with registered status outputs derived from the next state
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state_q       <= IDLE;
            BUSY_OUT      <= 1'b0;
            KEY_READY_OUT <= 1'b0;
        end else begin
            state_q       <= state_d;
            BUSY_OUT      <= (state_d == KEY_LOAD) || (state_d == KSA) || (state_d == DROP);
            KEY_READY_OUT <= (state_d == KEY_LOAD);
        end
    end

    // Key byte storage; contents are only meaningful up to the latched length
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN && !STOP_IN && key_acc_c) begin
            key_mem[KIDX_W'(load_idx_q)] <= KEY_BYTE_IN;
        end
    end

    // S-box, indices, counters and the output register
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            for (int n = 0; n < 256; n++) sbox[n] <= 8'(n);
            i_q            <= 8'd0;
            j_q            <= 8'd0;
            k_q            <= 8'd0;
            key_len_q      <= 8'd0;
            load_idx_q     <= 8'd0;
            drop_cnt_q     <= 16'd0;
            DATA_OUT       <= 8'd0;
            DATA_VALID_OUT <= 1'b0;
            ERROR_OUT      <= 1'b0;
        end else if (STOP_IN) begin
            DATA_VALID_OUT <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START_IN && key_legal_c) begin
                        for (int n = 0; n < 256; n++) sbox[n] <= 8'(n);
                        i_q        <= 8'd0;
                        j_q        <= 8'd0;
                        k_q        <= 8'd0;
                        load_idx_q <= 8'd0;
                        drop_cnt_q <= 16'd0;
                        key_len_q  <= KEY_SIZE_IN;
                        ERROR_OUT  <= 1'b0;
                    end else if (START_IN) begin
                        ERROR_OUT <= 1'b1;
                    end
                end
                KEY_LOAD: begin
                    if (key_acc_c) load_idx_q <= load_idx_q + 8'd1;
                end
                KSA: begin
                    sbox[i_q]     <= sbox[ksa_j_c];
                    sbox[ksa_j_c] <= ksa_si_c;
                    i_q           <= i_q + 8'd1;
                    j_q           <= (i_q == 8'hFF) ? 8'd0 : ksa_j_c;
                    k_q           <= (k_q == key_len_q - 8'd1) ? 8'd0 : k_q + 8'd1;
                end
                DROP: begin
                    sbox[p_i_c] <= p_sj_c;
                    sbox[p_j_c] <= p_si_c;
                    i_q         <= p_i_c;
                    j_q         <= p_j_c;
                    drop_cnt_q  <= drop_cnt_q + 16'd1;
                end
                STREAM: begin
                    if (data_acc_c) begin
                        sbox[p_i_c]    <= p_sj_c;
                        sbox[p_j_c]    <= p_si_c;
                        i_q            <= p_i_c;
                        j_q            <= p_j_c;
                        DATA_OUT       <= DATA_IN ^ p_k_c;
                        DATA_VALID_OUT <= 1'b1;
                    end else if (DATA_READY_IN) begin
                        DATA_VALID_OUT <= 1'b0;
                    end
                end
                default: DATA_VALID_OUT <= 1'b0;
            endcase
        end
    end
endmodule
